// File: rtl/fp64_to_int_if.sv
// Valid/ready handshake bundle between the FPU result stream, the fp64-to-integer
// converter and its integer consumer.
interface fp64_to_int_if #(
    parameter int INT_W = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_data;
    logic             in_signed;
    logic             in_rmode;
    logic             out_valid;
    logic             out_ready;
    logic [INT_W-1:0] out_data;
    logic             out_invalid;
    logic             out_inexact;

    modport master (
        output in_valid, in_data, in_signed, in_rmode, out_ready,
        input  in_ready, out_valid, out_data, out_invalid, out_inexact
    );

    modport slave (
        input  in_valid, in_data, in_signed, in_rmode, out_ready,
        output in_ready, out_valid, out_data, out_invalid, out_inexact
    );
endinterface

// File: rtl/fp64_to_int_conv.sv
// IEEE 754 double to signed/unsigned INT_W-bit integer converter with an iterative
// alignment shifter, RNE/RTZ rounding, saturation and invalid/inexact flags.
module fp64_to_int_conv #(
    parameter int INT_W      = 64,
    parameter int SHIFT_STEP = 8
) (
    input  logic          clk,
    input  logic          rst,
    fp64_to_int_if.slave  bus
);
    // Working magnitude must hold both the 53-bit mantissa and INT_W+1 integer bits.
    localparam int W     = (INT_W + 1 > 54) ? INT_W + 1 : 54;
    localparam int EXT_W = W + 1;

    localparam logic [10:0]      EXP_INT   = 11'd1075;
    localparam logic [10:0]      EXP_HALF  = 11'd1022;
    localparam logic [10:0]      EXP_SAT_S = 11'(1023 + INT_W - 1);
    localparam logic [10:0]      EXP_SAT_U = 11'(1023 + INT_W);
    localparam logic [6:0]       STEP_W    = 7'(SHIFT_STEP);
    localparam logic [INT_W-1:0] MAX_S     = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] MIN_S     = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0] MAX_U     = {INT_W{1'b1}};
    localparam logic [INT_W-1:0] ZERO_I    = {INT_W{1'b0}};
    localparam logic [INT_W-1:0] ONE_I     = {{(INT_W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     ONE_W     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     ZERO_W    = {W{1'b0}};
    localparam logic [W-1:0]     LIM_S     = ONE_W << (INT_W - 1);
    localparam logic [W-1:0]     LIM_U     = ONE_W << INT_W;
    localparam logic [EXT_W-1:0] ONE_X     = {{(EXT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_ROUND = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic             sgn_q, sgn_d;
    logic             rmode_q, rmode_d;
    logic             left_q, left_d;
    logic [6:0]       rem_q, rem_d;
    logic [W-1:0]     mag_q, mag_d;
    logic             guard_q, guard_d;
    logic             sticky_q, sticky_d;
    logic             out_valid_q, out_valid_d;
    logic [INT_W-1:0] out_data_q, out_data_d;
    logic             out_invalid_q, out_invalid_d;
    logic             out_inexact_q, out_inexact_d;

    // Saturation value for an out-of-range or infinite operand.
    function automatic logic [INT_W-1:0] sat_value(input logic neg, input logic sgn);
        logic [INT_W-1:0] v;
        if (sgn) begin
            v = neg ? MIN_S : MAX_S;
        end else begin
            v = neg ? ZERO_I : MAX_U;
        end
        return v;
    endfunction

    logic             in_sign_s;
    logic [10:0]      in_exp_s;
    logic [51:0]      in_frac_s;
    logic [52:0]      in_mant_s;
    logic             accept_s;
    logic             sat_pre_s;
    logic             right_s;
    logic [6:0]       shamt_s;
    logic [6:0]       step_s;
    logic [EXT_W-1:0] ext_s;
    logic [EXT_W-1:0] ext_shr_s;
    logic [EXT_W-1:0] drop_mask_s;
    logic             inc_s;
    logic [W-1:0]     rnd_s;
    logic             inx_s;

    assign in_sign_s = bus.in_data[63];
    assign in_exp_s  = bus.in_data[62:52];
    assign in_frac_s = bus.in_data[51:0];
    assign in_mant_s = {(in_exp_s != 11'd0), in_frac_s};
    assign accept_s  = bus.in_valid & (state_q == S_IDLE);

    // Exactly -2^(INT_W-1) is representable as signed, so it takes the normal path.
    assign sat_pre_s = bus.in_signed
                     ? ((in_exp_s >= EXP_SAT_S) &&
                        !(in_sign_s && (in_exp_s == EXP_SAT_S) && (in_frac_s == 52'd0)))
                     : (in_exp_s >= EXP_SAT_U);
    assign right_s   = (in_exp_s < EXP_INT);
    assign shamt_s   = right_s ? 7'(EXP_INT - in_exp_s) : 7'(in_exp_s - EXP_INT);

    // The guard bit rides below the magnitude so a right shift pushes bits through it.
    assign step_s      = (rem_q > STEP_W) ? STEP_W : rem_q;
    assign ext_s       = {mag_q, guard_q};
    assign ext_shr_s   = ext_s >> step_s;
    assign drop_mask_s = (ONE_X << step_s) - ONE_X;

    assign inc_s = ~rmode_q & guard_q & (sticky_q | mag_q[0]);
    assign rnd_s = mag_q + {{(W-1){1'b0}}, inc_s};
    assign inx_s = guard_q | sticky_q;

    // Next-state, datapath and result computation.
    always_comb begin
        state_d       = state_q;
        sign_d        = sign_q;
        sgn_d         = sgn_q;
        rmode_d       = rmode_q;
        left_d        = left_q;
        rem_d         = rem_q;
        mag_d         = mag_q;
        guard_d       = guard_q;
        sticky_d      = sticky_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_invalid_d = out_invalid_q;
        out_inexact_d = out_inexact_q;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    sign_d  = in_sign_s;
                    sgn_d   = bus.in_signed;
                    rmode_d = bus.in_rmode;
                    if (in_exp_s == 11'h7FF) begin
                        state_d       = S_OUT;
                        out_valid_d   = 1'b1;
                        out_invalid_d = 1'b1;
                        out_inexact_d = 1'b0;
                        if (in_frac_s != 52'd0) begin
                            out_data_d = bus.in_signed ? MAX_S : MAX_U;
                        end else begin
                            out_data_d = sat_value(in_sign_s, bus.in_signed);
                        end
                    end else if (sat_pre_s) begin
                        state_d       = S_OUT;
                        out_valid_d   = 1'b1;
                        out_invalid_d = 1'b1;
                        out_inexact_d = 1'b0;
                        out_data_d    = sat_value(in_sign_s, bus.in_signed);
                    end else if (in_exp_s < EXP_HALF) begin
                        state_d       = S_OUT;
                        out_valid_d   = 1'b1;
                        out_invalid_d = 1'b0;
                        out_inexact_d = (bus.in_data[62:0] != 63'd0);
                        out_data_d    = ZERO_I;
                    end else begin
                        left_d   = ~right_s;
                        rem_d    = shamt_s;
                        mag_d    = {{(W-53){1'b0}}, in_mant_s};
                        guard_d  = 1'b0;
                        sticky_d = 1'b0;
                        state_d  = (shamt_s == 7'd0) ? S_ROUND : S_SHIFT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                rem_d = rem_q - step_s;
                if (left_q) begin
                    mag_d = mag_q << step_s;
                end else begin
                    mag_d    = ext_shr_s[EXT_W-1:1];
                    guard_d  = ext_shr_s[0];
                    sticky_d = sticky_q | (|(ext_s & drop_mask_s));
                end
                if (rem_q <= STEP_W) begin
                    state_d = S_ROUND;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_ROUND: begin
                state_d     = S_OUT;
                out_valid_d = 1'b1;
                if (sgn_q) begin
                    if ((rnd_s > LIM_S) || ((rnd_s == LIM_S) && !sign_q)) begin
                        out_data_d    = sign_q ? MIN_S : MAX_S;
                        out_invalid_d = 1'b1;
                        out_inexact_d = 1'b0;
                    end else begin
                        out_data_d    = sign_q ? (~rnd_s[INT_W-1:0] + ONE_I) : rnd_s[INT_W-1:0];
                        out_invalid_d = 1'b0;
                        out_inexact_d = inx_s;
                    end
                end else if (sign_q) begin
                    out_data_d = ZERO_I;
                    if (rnd_s != ZERO_W) begin
                        out_invalid_d = 1'b1;
                        out_inexact_d = 1'b0;
                    end else begin
                        out_invalid_d = 1'b0;
                        out_inexact_d = inx_s;
                    end
                end else if (rnd_s >= LIM_U) begin
                    out_data_d    = MAX_U;
                    out_invalid_d = 1'b1;
                    out_inexact_d = 1'b0;
                end else begin
                    out_data_d    = rnd_s[INT_W-1:0];
                    out_invalid_d = 1'b0;
                    out_inexact_d = inx_s;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d     = S_OUT;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sign_q        <= 1'b0;
            sgn_q         <= 1'b0;
            rmode_q       <= 1'b0;
            left_q        <= 1'b0;
            rem_q         <= 7'd0;
            mag_q         <= ZERO_W;
            guard_q       <= 1'b0;
            sticky_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= ZERO_I;
            out_invalid_q <= 1'b0;
            out_inexact_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sign_q        <= sign_d;
            sgn_q         <= sgn_d;
            rmode_q       <= rmode_d;
            left_q        <= left_d;
            rem_q         <= rem_d;
            mag_q         <= mag_d;
            guard_q       <= guard_d;
            sticky_q      <= sticky_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_invalid_q <= out_invalid_d;
            out_inexact_q <= out_inexact_d;
        end
    end

    assign bus.in_ready    = (state_q == S_IDLE) & ~rst;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_invalid = out_invalid_q;
    assign bus.out_inexact = out_inexact_q;
endmodule

// File: tb/tb_fp64_to_int_conv.sv
// Self-checking bench for fp64_to_int_conv: directed corner cases plus random operands
// checked against an exact-arithmetic reference model.
module tb_fp64_to_int_conv;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fp64_to_int_if #(.INT_W(64)) bus ();

    fp64_to_int_conv #(.INT_W(64), .SHIFT_STEP(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: value = mant * 2^ex, rounded with exact integer remainder comparison.
    function automatic void ref_conv(input logic [63:0] x, input logic sgn, input logic rtz,
                                     output logic [63:0] d, output logic inv,
                                     output logic inx, output int lat);
        logic         neg;
        int           e;
        int           ex;
        int           sh;
        logic [52:0]  mant;
        logic [127:0] r;
        logic [127:0] q;
        logic [127:0] rem;
        logic [127:0] half;
        logic         big;
        logic         pre_sat;
        neg  = x[63];
        e    = int'(x[62:52]);
        mant = (e == 0) ? {1'b0, x[51:0]} : {1'b1, x[51:0]};
        ex   = (e == 0) ? -1074 : e - 1075;
        big  = 1'b0;
        inx  = 1'b0;
        r    = 128'd0;
        pre_sat = sgn ? ((e - 1023 >= 63) && !(neg && e == 1086 && x[51:0] == 52'd0))
                      : (e - 1023 >= 64);
        if (e == 2047 || e < 1022 || pre_sat) begin
            lat = 1;
        end else begin
            sh  = (52 - (e - 1023) < 0) ? (e - 1023) - 52 : 52 - (e - 1023);
            lat = 2 + (sh + 7) / 8;
        end
        if (e == 2047 && x[51:0] != 52'd0) begin
            d   = sgn ? 64'h7FFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
            inv = 1'b1;
            inx = 1'b0;
            return;
        end
        if (e == 2047 || ex >= 20) begin
            big = 1'b1;
        end else if (ex >= 0) begin
            r = 128'(mant) << ex;
        end else if (ex <= -64) begin
            inx = (mant != 53'd0);
        end else begin
            q    = 128'(mant) >> (-ex);
            rem  = 128'(mant) - (q << (-ex));
            half = 128'd1 << (-ex - 1);
            inx  = (rem != 128'd0);
            if (!rtz && (rem > half || (rem == half && q[0]))) q = q + 128'd1;
            r = q;
        end
        if (sgn) begin
            if (big || r > (128'd1 << 63) || (r == (128'd1 << 63) && !neg)) begin
                d   = neg ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
                inv = 1'b1;
                inx = 1'b0;
            end else begin
                d   = neg ? 64'(128'd0 - r) : r[63:0];
                inv = 1'b0;
            end
        end else if (neg) begin
            d = 64'd0;
            if (big || r != 128'd0) begin
                inv = 1'b1;
                inx = 1'b0;
            end else begin
                inv = 1'b0;
            end
        end else if (big || r >= (128'd1 << 64)) begin
            d   = 64'hFFFF_FFFF_FFFF_FFFF;
            inv = 1'b1;
            inx = 1'b0;
        end else begin
            d   = r[63:0];
            inv = 1'b0;
        end
    endfunction

    // One full transaction: accept, bounded wait for the result, compare, handshake.
    task automatic do_op(input string tag, input logic [63:0] x, input logic sgn, input logic rtz,
                         input logic [63:0] ed, input logic ei, input logic ex, input int el);
        int lat;
        bus.in_valid  = 1'b1;
        bus.in_data   = x;
        bus.in_signed = sgn;
        bus.in_rmode  = rtz;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, " data"}, bus.out_data, ed);
        chk({tag, " invalid"}, 64'(bus.out_invalid), 64'(ei));
        chk({tag, " inexact"}, 64'(bus.out_inexact), 64'(ex));
        chk({tag, " latency"}, 64'(lat), 64'(el));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_ref(input string tag, input logic [63:0] x, input logic sgn, input logic rtz);
        logic [63:0] ed;
        logic        ei;
        logic        ex;
        int          el;
        ref_conv(x, sgn, rtz, ed, ei, ex, el);
        do_op(tag, x, sgn, rtz, ed, ei, ex, el);
    endtask

    initial begin
        logic [63:0] x;
        int          e;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 64'd0;
        bus.in_signed = 1'b0;
        bus.in_rmode  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset out_data", bus.out_data, 64'd0);
        chk("reset invalid", 64'(bus.out_invalid), 64'd0);
        chk("reset inexact", 64'(bus.out_inexact), 64'd0);
        chk("reset in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle in_ready", 64'(bus.in_ready), 64'd1);

        do_op("1.5 rne", 64'h3FF8_0000_0000_0000, 1'b1, 1'b0, 64'd2, 1'b0, 1'b1, 9);
        do_op("1.5 rtz", 64'h3FF8_0000_0000_0000, 1'b1, 1'b1, 64'd1, 1'b0, 1'b1, 9);
        do_op("2.5 rne", 64'h4004_0000_0000_0000, 1'b1, 1'b0, 64'd2, 1'b0, 1'b1, 9);
        do_op("-3.0", 64'hC008_0000_0000_0000, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 9);
        do_op("nan", 64'h7FF8_0000_0000_0000, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1);
        do_op("+inf u", 64'h7FF0_0000_0000_0000, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1);
        do_op("-inf s", 64'hFFF0_0000_0000_0000, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1);
        do_op("-2^63 s", 64'hC3E0_0000_0000_0000, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 4);
        do_op("+2^63 s", 64'h43E0_0000_0000_0000, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1);
        do_op("+2^63 u", 64'h43E0_0000_0000_0000, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 4);
        do_op("-0.4 u", 64'hBFD9_9999_9999_999A, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1);
        do_op("-1.0 u", 64'hBFF0_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 9);
        do_op("2^52", 64'h4330_0000_0000_0000, 1'b1, 1'b0, 64'h0010_0000_0000_0000, 1'b0, 1'b0, 2);
        do_op("0.5 rne", 64'h3FE0_0000_0000_0000, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 9);
        do_op("0.75 rne", 64'h3FE8_0000_0000_0000, 1'b0, 1'b0, 64'd1, 1'b0, 1'b1, 9);
        do_op("-0.0", 64'h8000_0000_0000_0000, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1);

        // Output held under back-pressure while extra operands are offered.
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h4004_0000_0000_0000;
        bus.in_signed = 1'b1;
        bus.in_rmode  = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && bus.out_valid !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 64'h4330_0000_0000_0000;
            @(posedge clk);
            #1;
            chk("hold out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold data", bus.out_data, 64'd2);
            chk("hold inexact", 64'(bus.out_inexact), 64'd1);
            chk("hold in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ignored extra in_valid", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of alignment.
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hC008_0000_0000_0000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst shift out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst shift in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("post-rst no result", 64'(bus.out_valid), 64'd0);
        end
        do_op("after rst 1.5", 64'h3FF8_0000_0000_0000, 1'b1, 1'b0, 64'd2, 1'b0, 1'b1, 9);

        // Reset while a result is presented.
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h7FF8_0000_0000_0000;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("pre-rst out_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst out out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst out data", bus.out_data, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                e = int'($urandom_range(1015, 1092));
            end else if ($urandom_range(0, 3) == 0) begin
                e = 2047;
            end else begin
                e = int'($urandom_range(0, 2046));
            end
            x = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) x[39:0] = 40'd0;
            x[62:52] = 11'(e);
            do_ref("random", x, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
